// File: rtl/hrange_lanes.sv
// hrange_lanes: streams range(base, limit, step) as LANES values per beat
// behind a start/ready/valid/done handshake. A zero step is flagged as
// an error. All range arithmetic is done in a widened signed width, so
// values past the WIDTH range never wrap back into the range.
module hrange_lanes #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                     _clock,
  input  logic                     _reset,
  input  logic                     _start,
  input  logic signed [WIDTH-1:0]  base,
  input  logic signed [WIDTH-1:0]  limit,
  input  logic signed [WIDTH-1:0]  step,
  input  logic                     _ready,
  output logic                     _valid,
  output logic [WIDTH*LANES-1:0]   _0,
  output logic [LANES-1:0]         _mask,
  output logic                     _done,
  output logic                     _error
);

  // Extended width: room for LANES*step on top of any in-range cursor.
  localparam int EW = WIDTH + $clog2(LANES) + 2;

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  function automatic logic signed [EW-1:0] ext(input logic signed [WIDTH-1:0] v);
    return {{(EW-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic in_range(input logic signed [EW-1:0] v,
                                    input logic signed [EW-1:0] lim,
                                    input logic                 up);
    return up ? (v < lim) : (v > lim);
  endfunction

  state_t                  state_p0;
  logic signed [EW-1:0]    cur_p0;
  logic signed [EW-1:0]    lim_p0;
  logic signed [EW-1:0]    stp_p0;

  logic signed [EW-1:0]    src_cur;
  logic signed [EW-1:0]    src_lim;
  logic signed [EW-1:0]    src_stp;
  logic signed [EW-1:0]    acc;
  logic signed [EW-1:0]    nxt_cur;
  logic [LANES-1:0]        lane_ok;
  logic [WIDTH*LANES-1:0]  lane_bits;
  logic                    up;
  logic                    nxt_ok;
  logic                    is_last;

  // Beat builder: lanes, lane mask, next cursor and last flag from either
  // the fresh start operands or the running cursor.
  always_comb begin
    src_cur   = _start ? ext(base)  : cur_p0;
    src_lim   = _start ? ext(limit) : lim_p0;
    src_stp   = _start ? ext(step)  : stp_p0;
    up        = ~src_stp[EW-1];
    lane_ok   = '0;
    lane_bits = '0;
    acc       = src_cur;
    for (int k = 0; k < LANES; k++) begin
      lane_ok[k]                  = in_range(acc, src_lim, up);
      lane_bits[k*WIDTH +: WIDTH] = acc[WIDTH-1:0];
      acc                         = acc + src_stp;
    end
    nxt_cur = acc;
    nxt_ok  = in_range(acc, src_lim, up);
    is_last = (lane_ok != {LANES{1'b1}}) || !nxt_ok;
  end

  // Stage p0: control FSM and registered beat; start overrides reset.
  always_ff @(posedge _clock) begin
    if (_start) begin
      cur_p0 <= nxt_cur;
      lim_p0 <= ext(limit);
      stp_p0 <= ext(step);
      if (step == '0) begin
        _valid   <= 1'b0;
        _done    <= 1'b1;
        _error   <= 1'b1;
        state_p0 <= IDLE;
      end else if (!lane_ok[0]) begin
        _valid   <= 1'b0;
        _done    <= 1'b1;
        _error   <= 1'b0;
        state_p0 <= IDLE;
      end else begin
        _valid   <= 1'b1;
        _0       <= lane_bits;
        _mask    <= lane_ok;
        _done    <= 1'b0;
        _error   <= 1'b0;
        state_p0 <= is_last ? LAST : RUN;
      end
    end else if (_reset) begin
      state_p0 <= IDLE;
      _valid   <= 1'b0;
      _done    <= 1'b1;
      _error   <= 1'b0;
      _0       <= '0;
      _mask    <= '0;
    end else if (_valid && _ready) begin
      if (state_p0 == RUN) begin
        _0       <= lane_bits;
        _mask    <= lane_ok;
        cur_p0   <= nxt_cur;
        state_p0 <= is_last ? LAST : RUN;
      end else begin
        _valid   <= 1'b0;
        _done    <= 1'b1;
        state_p0 <= IDLE;
      end
    end
  end

endmodule

// File: doc/hrange_lanes.md
Name: hrange_lanes

Overview:
Parametrised successor to the single-value range generator. It streams the Python range(base, limit, step) sequence with a configurable data width, signed step in either direction, and LANES consecutive values per output beat. It sits behind the same start/ready/valid/done handshake used by the other generated function blocks, so callers can swap it in directly. It adds detection of an illegal zero step and range arithmetic that cannot overflow.

Parameters:
WIDTH, 32, signed width of base/limit/step and of each output lane
LANES, 4, values emitted per beat (>=1)

Ports:
_clock  in  1  sole clock, rising edge
_reset  in  1  synchronous, active-high reset
_start  in  1  capture base/limit/step this cycle and begin generating
base  in  WIDTH  signed first value
limit  in  WIDTH  signed exclusive bound
step  in  WIDTH  signed increment (positive or negative; zero is illegal)
_ready  in  1  caller accepts the current beat
_valid  out  1  beat on _0/_mask is valid
_0  out  WIDTH*LANES  lane k at bits [k*WIDTH +: WIDTH], signed
_mask  out  LANES  bit k set = lane k valid; always a contiguous prefix from bit 0
_done  out  1  level, high while idle/finished
_error  out  1  last run was started with step==0

Behaviour:
- Interface as decided: one clock (_clock); _reset is synchronous and active-high.
- Reset, sampled at the rising edge: _valid=0, _done=1, _error=0, _0=0, _mask=0, FSM to IDLE.
- _start in the same cycle as _reset: start wins.
- FSM states:
  - IDLE: _done=1. Beats are generated only after a start.
  - RUN: the current beat is presented; further beats follow.
  - LAST: the final beat is presented.
- Start, from any state (aborts any run in progress; a pending beat is discarded):
  - Latch base/limit/step. _done<=0, _error<=0.
  - step==0: next cycle _done=1, _error=1, _valid=0, state IDLE.
  - Empty range (base>=limit for step>0, base<=limit for step<0): next cycle _done=1, _valid=0, _error=0.
  - Otherwise the first beat is registered. _valid is high in the cycle after _start (1-cycle latency).
- Beat computation, from the cursor cur:
  - Lane k value v_k = cur + k*step.
  - Lane k is valid if v_k<limit (step>0) or v_k>limit (step<0).
  - All compares use WIDTH+clog2(LANES)+2 bit signed extended arithmetic, so values past the WIDTH range never wrap back into range.
  - Next cursor = cur + LANES*step, in the same extended width.
- Last-beat detection:
  - A beat is last if its mask is not all-ones, or the next cursor's lane 0 is invalid.
  - A last beat puts the FSM in LAST; otherwise RUN.
- Handshake:
  - A transfer occurs when _valid && _ready.
  - While _valid && !_ready, _0/_mask/_valid hold stable.
  - On a transfer in RUN, the next beat is registered for the following cycle, giving 1 beat/cycle with _ready held high.
  - On a transfer in LAST: _valid<=0, _done<=1, state IDLE.
  - When _valid=0, the _ready value is ignored.
- Invalid lanes of _0 hold don't-care; the bench checks only lanes whose _mask bit is set.
- _error is held until the next _start or _reset.

Test Plan:
1. WIDTH=32, LANES=4, base=0, limit=10, step=2, _ready=1 -> beat {0,2,4,6} mask 1111, then {8} mask 0001; _done=1 on the cycle after the 2nd transfer; exactly 2 transfers.
2. base=10, limit=0, step=-3 -> beat {10,7,4,1} mask 1111 flagged last; _done follows the transfer.
3. base=5, limit=5, step=1 -> no _valid, _done=1 one cycle after start, _error=0. Then step=0 -> _done=1, _error=1, no beats.
4. Scenario 1 with _ready low for 3 cycles after the first _valid -> {0,2,4,6} held stable for all 3 cycles, then the sequence resumes unchanged.
5. WIDTH=8, base=120, limit=127, step=5 -> single beat {120,125} mask 0011, then done. No wrap to negative values, no infinite run.
6. Mid-stream:
   - Assert _reset during RUN -> next cycle _valid=0, _done=1.
   - Assert _start(0,3,1) during RUN -> old beat dropped, next beat {0,1,2} mask 0111.
   - Assert _reset and _start together -> start wins.
